stage5_rx: RTL

//   Receive-side decoder for the 7-bit stage5 output word stream.
//   - Recovers the 5-bit payload word[4:0] into a small FIFO with a valid/ready output.
//   - Checks the duplicated pair flag for internal agreement (word[5] == word[6]).
//   - Checks the pair flag against the stream: word[5] of word N must equal

---
 rtl/stage5_rx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/stage5_rx.sv
// Receive-side decoder for the stage5 word stream: payload FIFO, duplicate-flag
// check, pair-flag sequence check and a saturating error counter.
module stage5_rx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic [6:0]               word_i,
    input  logic                     word_valid_i,
    output logic [4:0]               data_o,
    output logic                     data_valid_o,
    input  logic                     data_ready_i,
    output logic                     dup_err_o,
    output logic                     seq_err_o,
    output logic [CNT_W-1:0]         err_cnt_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [4:0]        mem_q [DEPTH];
    logic [4:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              prev_b0_q, prev_b0_d;
    logic              prev_flag_q, prev_flag_d;
    logic              prev_vld_q, prev_vld_d;
    logic              dup_err_q, dup_err_d;
    logic              seq_err_q, seq_err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              overflow_q, overflow_d;

    logic              pop;
    logic              push;
    logic              full;
    logic [1:0]        inc;
    logic [CNT_W:0]    cnt_sum;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        prev_b0_d   = prev_b0_q;
        prev_flag_d = prev_flag_q;
        prev_vld_d  = prev_vld_q;
        overflow_d  = overflow_q;

        pop  = (fill_q != '0) && data_ready_i;
        full = (fill_q == FILL_W'(DEPTH));
        push = word_valid_i && (!full || pop);

        dup_err_d = word_valid_i && (word_i[5] != word_i[6]);
        seq_err_d = word_valid_i && prev_vld_q
                    && (prev_flag_q != (prev_b0_q & word_i[0]));

        if (push) begin
            mem_d[wr_ptr_q] = word_i[4:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop) fill_d = fill_q + FILL_W'(1);
        else if (!push && pop) fill_d = fill_q - FILL_W'(1);

        if (word_valid_i && !push) overflow_d = 1'b1;

        // Prev registers track every valid word, including dropped ones.
        if (word_valid_i) begin
            prev_b0_d   = word_i[0];
            prev_flag_d = word_i[5];
            prev_vld_d  = 1'b1;
        end

        inc     = {1'b0, dup_err_d} + {1'b0, seq_err_d};
        cnt_sum = {1'b0, err_cnt_q} + (CNT_W + 1)'(inc);
        err_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fill_d      = '0;
            prev_b0_d   = 1'b0;
            prev_flag_d = 1'b0;
            prev_vld_d  = 1'b0;
            dup_err_d   = 1'b0;
            seq_err_d   = 1'b0;
            err_cnt_d   = '0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            prev_b0_q   <= 1'b0;
            prev_flag_q <= 1'b0;
            prev_vld_q  <= 1'b0;
            dup_err_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            prev_b0_q   <= prev_b0_d;
            prev_flag_q <= prev_flag_d;
            prev_vld_q  <= prev_vld_d;
            dup_err_q   <= dup_err_d;
            seq_err_q   <= seq_err_d;
            err_cnt_q   <= err_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign data_o       = mem_q[rd_ptr_q];
    assign data_valid_o = (fill_q != '0);
    assign dup_err_o    = dup_err_q;
    assign seq_err_o    = seq_err_q;
    assign err_cnt_o    = err_cnt_q;
    assign overflow_o   = overflow_q;
    assign fill_o       = fill_q;

endmodule
